// File: rtl/id_issue_ctrl.sv
// ---------------------------------------------------------------------------
// id_issue_ctrl
//
// Decode/issue stage between the byte-wide instruction fetch and the EX-stage
// ALU. Each accepted byte is decoded into opcode, register selects and an
// immediate, which appear registered the cycle after the accept.
//
// Special sequences:
//   - LOADIMM (op F) is two bytes: the opcode byte, then a raw data byte that
//     becomes dec_imm. The data byte is never decoded.
//   - A conditional branch (op A/B) that directly follows an issued
//     flag-setting op (1-5) waits one bubble cycle. The ALU updates {Z,N} on
//     the falling edge, so one extra rising edge guarantees the flags reflect
//     that op before the branch condition is sampled.
//   - A taken branch pulses br_taken for one cycle. The fetch byte offered in
//     that cycle is wrong-path and is not accepted.
//
// Optional build macro:
//   ILLEGAL_TRAP_EN - opcodes 0, C and D set the sticky `illegal` flag and
//                     park the decoder in S_HALT until reset. Without the
//                     macro those opcodes issue as NOPs and `illegal` is 0.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   instr         fetch byte: [7:4] op, [3:2] ra, [1:0] rb
//   instr_valid   fetch byte valid
//   instr_ready   decoder accepts the byte this cycle
//   stall_in      EX back-pressure; freezes all issue outputs and state
//   rb_data       register-file read of instr[1:0] (branch target source)
//   zn            ALU flags {Z,N}
//   dec_valid     issue outputs carry a real instruction
//   dec_op        opcode to ALU (0 for NOP-class opcodes)
//   dec_ra/dec_rb register selects
//   dec_imm       LOADIMM immediate, else 0
//   dec_wen       register write enable
//   br_taken      one-cycle redirect pulse to fetch
//   br_target     redirect address
//   illegal       sticky illegal-opcode flag (trap build only)
// ---------------------------------------------------------------------------
module id_issue_ctrl #(
    parameter int OPW = 4,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW+3:0] instr,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic           stall_in,
    input  logic [DW-1:0]  rb_data,
    input  logic [1:0]     zn,
    output logic           dec_valid,
    output logic [OPW-1:0] dec_op,
    output logic [1:0]     dec_ra,
    output logic [1:0]     dec_rb,
    output logic [DW-1:0]  dec_imm,
    output logic           dec_wen,
    output logic           br_taken,
    output logic [DW-1:0]  br_target,
    output logic           illegal
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [OPW-1:0] OP_NOP   = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_SHR   = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_IN    = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_MOV   = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_BR    = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_BRZ   = OPW'(4'hA);
    localparam logic [OPW-1:0] OP_BRN   = OPW'(4'hB);
    localparam logic [OPW-1:0] OP_RSV_C = OPW'(4'hC);
    localparam logic [OPW-1:0] OP_RSV_D = OPW'(4'hD);
    localparam logic [OPW-1:0] OP_LDI   = OPW'(4'hF);

    typedef enum logic [1:0] {
        S_OP,
        S_IMM,
        S_WAIT
`ifdef ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    function automatic logic is_flag_op(input logic [OPW-1:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

    function automatic logic is_wen_op(input logic [OPW-1:0] op);
        return is_flag_op(op) || (op == OP_IN) || (op == OP_MOV) || (op == OP_LDI);
    endfunction

    function automatic logic is_nop_op(input logic [OPW-1:0] op);
        return (op == OP_NOP) || (op == OP_RSV_C) || (op == OP_RSV_D);
    endfunction

    function automatic logic is_cond_br(input logic [OPW-1:0] op);
        return (op == OP_BRZ) || (op == OP_BRN);
    endfunction

    function automatic logic is_branch(input logic [OPW-1:0] op);
        return (op == OP_BR) || is_cond_br(op);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state;
    logic            last_flag_op;
    // Byte held across S_IMM (ra of LOADIMM) or S_WAIT (whole branch byte).
    logic [OPW+3:0]  hold_byte;
    logic [DW-1:0]   hold_rb;

    // Next-state values
    state_t          state_nxt;
    logic            last_flag_nxt;
    logic [OPW+3:0]  hold_byte_nxt;
    logic [DW-1:0]   hold_rb_nxt;
    logic            valid_nxt;
    logic [OPW-1:0]  op_nxt;
    logic [1:0]      ra_nxt;
    logic [1:0]      rb_nxt;
    logic [DW-1:0]   imm_nxt;
    logic            wen_nxt;
    logic            br_nxt;
    logic [DW-1:0]   tgt_nxt;
    logic            illegal_nxt;

    // Issue request assembled by the state logic
    logic            iss;
    logic [OPW-1:0]  iss_op;
    logic [1:0]      iss_ra;
    logic [1:0]      iss_rb;
    logic [DW-1:0]   iss_imm;
    logic [DW-1:0]   iss_tgt;

    logic [OPW-1:0]  in_op;
    logic [OPW-1:0]  hold_op;
    logic            accept;

    assign in_op   = instr[OPW+3:4];
    assign hold_op = hold_byte[OPW+3:4];

    // The br_taken cycle is the redirect shadow: the byte on the bus is
    // from the wrong path, so it must not be taken.
    assign instr_ready = !stall_in && !br_taken && ((state == S_OP) || (state == S_IMM));
    assign accept      = instr_valid && instr_ready;

    // ------------------------------------------------------------------
    // Next-state and issue logic
    // ------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        last_flag_nxt = last_flag_op;
        hold_byte_nxt = hold_byte;
        hold_rb_nxt   = hold_rb;
        valid_nxt     = dec_valid;
        op_nxt        = dec_op;
        ra_nxt        = dec_ra;
        rb_nxt        = dec_rb;
        imm_nxt       = dec_imm;
        wen_nxt       = dec_wen;
        br_nxt        = br_taken;
        tgt_nxt       = br_target;
        illegal_nxt   = illegal;

        iss     = 1'b0;
        iss_op  = OP_NOP;
        iss_ra  = '0;
        iss_rb  = '0;
        iss_imm = '0;
        iss_tgt = '0;

        // Under stall every default above is a hold; nothing else happens.
        if (!stall_in) begin
            // Single-cycle outputs fall unless an issue re-asserts them.
            valid_nxt = 1'b0;
            wen_nxt   = 1'b0;
            br_nxt    = 1'b0;

            case (state)
                S_OP: begin
                    if (accept) begin
                        if (in_op == OP_LDI) begin
                            hold_byte_nxt = instr;
                            state_nxt     = S_IMM;
                        end else if (is_cond_br(in_op) && last_flag_op) begin
                            // Flags from the preceding op are not settled
                            // yet: park the branch for one bubble cycle.
                            hold_byte_nxt = instr;
                            hold_rb_nxt   = rb_data;
                            state_nxt     = S_WAIT;
                        end
`ifdef ILLEGAL_TRAP_EN
                        else if (is_nop_op(in_op)) begin
                            illegal_nxt = 1'b1;
                            state_nxt   = S_HALT;
                        end
`endif
                        else begin
                            iss     = 1'b1;
                            iss_op  = is_nop_op(in_op) ? OP_NOP : in_op;
                            iss_ra  = instr[3:2];
                            iss_rb  = instr[1:0];
                            iss_tgt = rb_data;
                        end
                    end
                end

                S_IMM: begin
                    // The byte is raw immediate data regardless of its value.
                    if (accept) begin
                        iss       = 1'b1;
                        iss_op    = OP_LDI;
                        iss_ra    = hold_byte[3:2];
                        iss_imm   = DW'(instr);
                        state_nxt = S_OP;
                    end
                end

                S_WAIT: begin
                    iss       = 1'b1;
                    iss_op    = hold_op;
                    iss_ra    = hold_byte[3:2];
                    iss_rb    = hold_byte[1:0];
                    iss_tgt   = hold_rb;
                    state_nxt = S_OP;
                end

`ifdef ILLEGAL_TRAP_EN
                S_HALT: state_nxt = S_HALT;
`endif

                default: state_nxt = S_OP;
            endcase

            if (iss) begin
                valid_nxt     = 1'b1;
                op_nxt        = iss_op;
                ra_nxt        = iss_ra;
                rb_nxt        = iss_rb;
                imm_nxt       = iss_imm;
                wen_nxt       = is_wen_op(iss_op);
                last_flag_nxt = is_flag_op(iss_op);
                if (is_branch(iss_op)) begin
                    // zn is sampled on the issuing edge.
                    tgt_nxt = iss_tgt;
                    br_nxt  = (iss_op == OP_BR)
                           || ((iss_op == OP_BRZ) && zn[1])
                           || ((iss_op == OP_BRN) && zn[0]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_OP;
            last_flag_op <= 1'b0;
            // NOTE: the hold registers are reset too even though they are
            // only read after being written; it keeps X out of simulation
            // and costs nothing on a few flops.
            hold_byte    <= '0;
            hold_rb      <= '0;
            dec_valid    <= 1'b0;
            dec_op       <= '0;
            dec_ra       <= '0;
            dec_rb       <= '0;
            dec_imm      <= '0;
            dec_wen      <= 1'b0;
            br_taken     <= 1'b0;
            br_target    <= '0;
        end else begin
            state        <= state_nxt;
            last_flag_op <= last_flag_nxt;
            hold_byte    <= hold_byte_nxt;
            hold_rb      <= hold_rb_nxt;
            dec_valid    <= valid_nxt;
            dec_op       <= op_nxt;
            dec_ra       <= ra_nxt;
            dec_rb       <= rb_nxt;
            dec_imm      <= imm_nxt;
            dec_wen      <= wen_nxt;
            br_taken     <= br_nxt;
            br_target    <= tgt_nxt;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else begin
            illegal <= illegal_nxt;
        end
    end
`else
    assign illegal = 1'b0;

    // The next-value is computed uniformly but has no consumer here.
    logic unused_illegal;
    assign unused_illegal = illegal_nxt;
`endif

endmodule
